// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digit value, blanking gap between digits.
// Optional leading-zero suppression is built when SEG7_SCAN_LZ_BLANK_EN is defined.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [3:0]              n_sel,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  // state | meaning
  // GAP   | all anodes off between digits; n_sel (and swap) latched on the last cycle
  // SHOW  | anode idx lit (if enabled) for REFRESH_DIV cycles
  localparam logic [0:0] ST_GAP  = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int TW   = $clog2(CMAX);

  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] SHOW_PEN  = TW'(REFRESH_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [0:0]              state, state_next;
  logic [TW-1:0]           tick, tick_next;
  logic [IW-1:0]           idx, idx_next;
  logic [4*NUM_DIGITS-1:0] disp_reg, pending, disp_next;
  logic                    pend_valid;
  logic                    gap_end, show_end, swap, show_next;
  logic                    blank_next;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    dp_next, fd_next;

  always_comb begin
    gap_end   = (state == ST_GAP)  && (tick == GAP_LAST);
    show_end  = (state == ST_SHOW) && (tick == SHOW_LAST);
    swap      = gap_end && (idx == '0) && pend_valid;
    disp_next = swap ? pending : disp_reg;

    idx_next = idx;
    if (show_end) idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    state_next = state;
    tick_next  = tick + 1'b1;
    if (gap_end) begin
      state_next = ST_SHOW;
      tick_next  = '0;
    end else if (show_end) begin
      state_next = ST_GAP;
      tick_next  = '0;
    end
    show_next = (state_next == ST_SHOW);

    // registered pulse must land on the last SHOW cycle, so decode one cycle early
    fd_next = (state == ST_SHOW) && (tick == SHOW_PEN) && (idx == IDX_LAST);
  end

`ifdef SEG7_SCAN_LZ_BLANK_EN
  logic digit_blank, lz_hit;

  always_comb begin
    lz_hit = (idx != '0);
    for (int j = 0; j < NUM_DIGITS; j++)
      if ((j >= int'(idx)) && (disp_next[4*j +: 4] != 4'h0)) lz_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       digit_blank <= 1'b0;
    else if (gap_end) digit_blank <= lz_hit;
  end

  assign blank_next = gap_end ? lz_hit : digit_blank;
`else
  assign blank_next = 1'b0;
`endif

  // while SHOW continues idx_next equals idx, so idx selects the lit digit
  always_comb begin
    an_next = '1;
    dp_next = 1'b1;
    if (show_next && !blank_next) begin
      an_next[idx] = ~digit_en[idx];
      dp_next      = ~(dp_mask[idx] & digit_en[idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_GAP;
      tick       <= '0;
      idx        <= '0;
      disp_reg   <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      n_sel      <= 4'h0;
      an_n       <= '1;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      tick       <= tick_next;
      idx        <= idx_next;
      an_n       <= an_next;
      dp_n       <= dp_next;
      frame_done <= fd_next;
      if (gap_end) n_sel <= disp_next[4*idx +: 4];
      if (swap) disp_reg <= pending;
      // a load coinciding with the swap refills pending for the following frame
      if (load) begin
        pending    <= value;
        pend_valid <= 1'b1;
      end else if (swap) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=2 (24-cycle frame).
// Builds with or without SEG7_SCAN_LZ_BLANK_EN; the expected pattern follows the same macro.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  n_sel;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .digit_en(digit_en), .dp_mask(dp_mask),
    .n_sel(n_sel), .an_n(an_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [3:0] nsel;
    logic       lit;
    logic       fd;
  } exp_t;

  // Expected outputs at cycle c (0..23) of a frame displaying v: 2 gap + 4 show cycles per digit.
  function automatic exp_t model(int c, logic [15:0] v);
    exp_t e;
    int d;
    logic blank;
    d      = c / 6;
    blank  = 1'b0;
`ifdef SEG7_SCAN_LZ_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0) blank = 1'b1;
`endif
    e.lit  = (c % 6) >= 2;
    e.nsel = v[4*d +: 4];
    e.fd   = (c == 23);
    e.an   = 4'hF;
    e.dp   = 1'b1;
    if (e.lit && !blank) begin
      e.an[d] = ~digit_en[d];
      e.dp    = ~(dp_mask[d] & digit_en[d]);
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an_n got %h want f", an_n); end
    checks++; if (n_sel !== 4'h0) begin errors++; $display("FAIL reset_n_sel got %h want 0", n_sel); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp_n got %b want 1", dp_n); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    rst_n = 1'b1;
  endtask

  // Frames after reset: loads mid-frame, repeated loads, load on the swap cycle, digit_en/dp_mask.
  task automatic test_scan();
    logic [15:0] shown [8] = '{16'h0000, 16'h3A7C, 16'h2222, 16'h1111,
                               16'h5555, 16'h6666, 16'h7777, 16'h7777};
    int          la_c  [8] = '{10, 5, 9, 3, 20, 1, -1, -1};
    logic [15:0] la_v  [8] = '{16'h3A7C, 16'h2222, 16'h1111, 16'h4444,
                               16'h6666, 16'h7777, 16'h0, 16'h0};
    int          lb_c  [8] = '{-1, -1, -1, 15, -1, -1, -1, -1};
    logic [15:0] lb_v  [8] = '{16'h0, 16'h0, 16'h0, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0};
    exp_t e;
    for (int f = 0; f < 8; f++) begin
      if (f == 6) begin digit_en = 4'b1010; dp_mask = 4'b0011; end
      if (f == 7) begin digit_en = 4'hF;    dp_mask = 4'h0;    end
      for (int c = 0; c < 24; c++) begin
        e = model(c, shown[f]);
        checks++;
        if (an_n !== e.an) begin errors++; $display("FAIL scan_an_n f%0d c%0d got %h want %h", f, c, an_n, e.an); end
        checks++;
        if (dp_n !== e.dp) begin errors++; $display("FAIL scan_dp_n f%0d c%0d got %b want %b", f, c, dp_n, e.dp); end
        checks++;
        if (frame_done !== e.fd) begin errors++; $display("FAIL scan_frame_done f%0d c%0d got %b want %b", f, c, frame_done, e.fd); end
        if (e.lit) begin
          checks++;
          if (n_sel !== e.nsel) begin errors++; $display("FAIL scan_n_sel f%0d c%0d got %h want %h", f, c, n_sel, e.nsel); end
        end
        load  = (c == la_c[f]) || (c == lb_c[f]);
        value = (c == lb_c[f]) ? lb_v[f] : la_v[f];
        @(negedge clk);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    repeat (14) @(negedge clk);
    checks++; if (an_n !== 4'hB) begin errors++; $display("FAIL pre_reset_an_n got %h want b", an_n); end
    checks++; if (n_sel !== 4'h7) begin errors++; $display("FAIL pre_reset_n_sel got %h want 7", n_sel); end
    rst_n = 1'b0;
    #1;
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL async_an_n got %h want f", an_n); end
    checks++; if (n_sel !== 4'h0) begin errors++; $display("FAIL async_n_sel got %h want 0", n_sel); end
    checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL async_dp_n got %b want 1", dp_n); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      e = model(c, 16'h0000);
      checks++;
      if (an_n !== e.an) begin errors++; $display("FAIL restart_an_n c%0d got %h want %h", c, an_n, e.an); end
      checks++;
      if (frame_done !== e.fd) begin errors++; $display("FAIL restart_frame_done c%0d got %b want %b", c, frame_done, e.fd); end
      if (e.lit) begin
        checks++;
        if (n_sel !== e.nsel) begin errors++; $display("FAIL restart_n_sel c%0d got %h want %h", c, n_sel, e.nsel); end
      end
      @(negedge clk);
    end
  endtask

  // Leading-zero values; expected anodes depend on whether suppression is built in.
  task automatic test_lz_blank();
    logic [15:0] shown [3] = '{16'h0000, 16'h0050, 16'h0000};
    int          la_c  [3] = '{7, 4, -1};
    logic [15:0] la_v  [3] = '{16'h0050, 16'h0000, 16'h0};
    exp_t e;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 24; c++) begin
        e = model(c, shown[f]);
        checks++;
        if (an_n !== e.an) begin errors++; $display("FAIL lz_an_n f%0d c%0d got %h want %h", f, c, an_n, e.an); end
        checks++;
        if (dp_n !== e.dp) begin errors++; $display("FAIL lz_dp_n f%0d c%0d got %b want %b", f, c, dp_n, e.dp); end
        if (e.lit) begin
          checks++;
          if (n_sel !== e.nsel) begin errors++; $display("FAIL lz_n_sel f%0d c%0d got %h want %h", f, c, n_sel, e.nsel); end
        end
        load  = (c == la_c[f]);
        value = la_v[f];
        @(negedge clk);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_async_reset();
    test_lz_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
